lsu_mem_stage: RTL and testbench

Load/store unit memory stage sitting directly upstream of the data cache. It accepts one memory micro-op at a time from the execute stage and checks alignment and encoding. It issues a word-aligned request with byte strobes and lane-shifted store data to the D$ request channel, waits for the D$ response, then sign/zero-extends load data and hands the result to writeback. Only one transaction is outstanding; misaligned or illegal encodings never reach the D$ and are reported as exceptions on the writeback channel.

---
 rtl/lsu_mem_stage_if.sv | 60 ++++++
 rtl/lsu_mem_stage.sv | 208 ++++++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_stage_if.sv
// ---------------------------------------------------------------------------
// lsu_mem_stage_if
//   Bundles the three channels around the LSU memory stage:
//     ex_*    : execute stage -> LSU (one memory micro-op, valid/ready)
//     cpu_* / dcache_* : LSU <-> data cache request and response channels
//     wb_*    : LSU -> writeback (completion or exception, valid/ready)
//   modport slave  : the LSU itself (consumes ex/dcache, drives cpu/wb)
//   modport master : the surrounding pipeline / test environment
// ---------------------------------------------------------------------------
interface lsu_mem_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    // execute -> LSU
    logic                    ex_valid_i;
    logic                    lsu_ready_o;
    logic                    ex_is_store_i;
    logic [2:0]              ex_funct3_i;
    logic [ADDR_WIDTH-1:0]   ex_addr_i;
    logic [DATA_WIDTH-1:0]   ex_wdata_i;
    logic [4:0]              ex_rd_i;
    // LSU -> D$ request
    logic                    cpu_req_valid_o;
    logic                    dcache_req_ready_i;
    logic                    cpu_we_o;
    logic [ADDR_WIDTH-1:0]   cpu_addr_o;
    logic [DATA_WIDTH-1:0]   cpu_wdata_o;
    logic [DATA_WIDTH/8-1:0] cpu_wstrb_o;
    // D$ -> LSU response
    logic                    dcache_resp_valid_i;
    logic                    cpu_resp_ready_o;
    logic [DATA_WIDTH-1:0]   dcache_rdata_i;
    // LSU -> writeback
    logic                    wb_valid_o;
    logic                    wb_ready_i;
    logic                    wb_rf_we_o;
    logic [4:0]              wb_rd_o;
    logic [DATA_WIDTH-1:0]   wb_data_o;
    logic                    wb_exc_o;
    logic [3:0]              wb_exc_cause_o;
    logic [ADDR_WIDTH-1:0]   wb_exc_tval_o;

    modport slave (
        input  ex_valid_i, ex_is_store_i, ex_funct3_i, ex_addr_i, ex_wdata_i, ex_rd_i,
        input  dcache_req_ready_i, dcache_resp_valid_i, dcache_rdata_i, wb_ready_i,
        output lsu_ready_o, cpu_req_valid_o, cpu_we_o, cpu_addr_o, cpu_wdata_o,
        output cpu_wstrb_o, cpu_resp_ready_o,
        output wb_valid_o, wb_rf_we_o, wb_rd_o, wb_data_o, wb_exc_o,
        output wb_exc_cause_o, wb_exc_tval_o
    );

    modport master (
        output ex_valid_i, ex_is_store_i, ex_funct3_i, ex_addr_i, ex_wdata_i, ex_rd_i,
        output dcache_req_ready_i, dcache_resp_valid_i, dcache_rdata_i, wb_ready_i,
        input  lsu_ready_o, cpu_req_valid_o, cpu_we_o, cpu_addr_o, cpu_wdata_o,
        input  cpu_wstrb_o, cpu_resp_ready_o,
        input  wb_valid_o, wb_rf_we_o, wb_rd_o, wb_data_o, wb_exc_o,
        input  wb_exc_cause_o, wb_exc_tval_o
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// ---------------------------------------------------------------------------
// lsu_mem_stage
//   Memory stage of the load/store unit, directly upstream of the D$.
//   Accepts one op at a time, rejects illegal/misaligned ops as exceptions
//   without touching the D$, otherwise issues a word-aligned request with
//   byte strobes and lane-replicated store data, waits for the response and
//   returns sign/zero-extended load data to writeback.
//   Ports:
//     clk_i  : clock, rising edge
//     rst_ni : asynchronous active-low reset
//     bus    : lsu_mem_stage_if.slave (ex, D$ req/resp, wb channels)
//   All outputs are registered or decoded from the state register only.
// ---------------------------------------------------------------------------
module lsu_mem_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    lsu_mem_stage_if.slave bus
);
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, WB} state_e;

    state_e                state_q,    state_d;
    logic                  is_store_q, is_store_d;
    logic [2:0]            funct3_q,   funct3_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;     // already lane-replicated
    logic [STRB_W-1:0]     wstrb_q,    wstrb_d;
    logic [4:0]            rd_q,       rd_d;
    logic                  wb_rf_we_q, wb_rf_we_d;
    logic [DATA_WIDTH-1:0] wb_data_q,  wb_data_d;
    logic                  wb_exc_q,   wb_exc_d;
    logic [3:0]            cause_q,    cause_d;
    logic [ADDR_WIDTH-1:0] tval_q,     tval_d;

    // Decode of the op currently offered by execute.
    logic                  ex_legal;
    logic                  ex_misaligned;
    logic [1:0]            ex_off;
    logic [STRB_W-1:0]     ex_wstrb;
    logic [DATA_WIDTH-1:0] ex_wdata;

    always_comb begin
        ex_off        = bus.ex_addr_i[1:0];
        ex_legal      = 1'b0;
        ex_misaligned = 1'b0;
        ex_wstrb      = '0;
        ex_wdata      = bus.ex_wdata_i;

        if (bus.ex_is_store_i) begin
            ex_legal = (bus.ex_funct3_i inside {3'b000, 3'b001, 3'b010});
        end else begin
            ex_legal = (bus.ex_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end

        // funct3[1:0] is the access size: 00 byte, 01 half, 10 word.
        case (bus.ex_funct3_i[1:0])
            2'b00: begin
                ex_wstrb = STRB_W'(4'b0001) << ex_off;
                ex_wdata = {4{bus.ex_wdata_i[7:0]}};
            end
            2'b01: begin
                ex_misaligned = ex_off[0];
                ex_wstrb      = STRB_W'(4'b0011) << ex_off;
                ex_wdata      = {2{bus.ex_wdata_i[15:0]}};
            end
            default: begin
                ex_misaligned = (ex_off != 2'b00);
                ex_wstrb      = '1;
            end
        endcase

        if (!bus.ex_is_store_i) begin
            ex_wstrb = '0;
        end
    end

    // Load extraction from the registered address offset and funct3.
    logic [DATA_WIDTH-1:0] rdata_shift;
    logic [DATA_WIDTH-1:0] ld_data;

    always_comb begin
        rdata_shift = bus.dcache_rdata_i >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'b000:  ld_data = {{(DATA_WIDTH-8){rdata_shift[7]}},   rdata_shift[7:0]};
            3'b001:  ld_data = {{(DATA_WIDTH-16){rdata_shift[15]}}, rdata_shift[15:0]};
            3'b100:  ld_data = {{(DATA_WIDTH-8){1'b0}},             rdata_shift[7:0]};
            3'b101:  ld_data = {{(DATA_WIDTH-16){1'b0}},            rdata_shift[15:0]};
            default: ld_data = rdata_shift;
        endcase
    end

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves a latch.
        state_d    = state_q;
        is_store_d = is_store_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rd_d       = rd_q;
        wb_rf_we_d = wb_rf_we_q;
        wb_data_d  = wb_data_q;
        wb_exc_d   = wb_exc_q;
        cause_d    = cause_q;
        tval_d     = tval_q;

        case (state_q)
            IDLE: begin
                if (bus.ex_valid_i) begin
                    is_store_d = bus.ex_is_store_i;
                    funct3_d   = bus.ex_funct3_i;
                    addr_d     = bus.ex_addr_i;
                    wdata_d    = ex_wdata;
                    wstrb_d    = ex_wstrb;
                    rd_d       = bus.ex_rd_i;
                    wb_rf_we_d = 1'b0;
                    wb_data_d  = '0;
                    wb_exc_d   = 1'b0;
                    cause_d    = 4'd0;
                    tval_d     = '0;
                    // Illegal encoding wins over misalignment.
                    if (!ex_legal) begin
                        wb_exc_d = 1'b1;
                        cause_d  = 4'd2;
                        state_d  = WB;
                    end else if (ex_misaligned) begin
                        wb_exc_d = 1'b1;
                        cause_d  = bus.ex_is_store_i ? 4'd6 : 4'd4;
                        tval_d   = bus.ex_addr_i;
                        state_d  = WB;
                    end else begin
                        state_d  = REQ;
                    end
                end
            end
            REQ: begin
                if (bus.dcache_req_ready_i) state_d = WAIT_RESP;
            end
            WAIT_RESP: begin
                // Stores also wait here so completion follows the D$ write.
                if (bus.dcache_resp_valid_i) begin
                    state_d = WB;
                    if (!is_store_q) begin
                        wb_data_d  = ld_data;
                        wb_rf_we_d = (rd_q != 5'd0);
                    end
                end
            end
            WB: begin
                if (bus.wb_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: captured registers are cleared on reset so every output except
    // lsu_ready_o reads 0 while rst_ni is low.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            is_store_q <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rd_q       <= '0;
            wb_rf_we_q <= 1'b0;
            wb_data_q  <= '0;
            wb_exc_q   <= 1'b0;
            cause_q    <= '0;
            tval_q     <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q    <= state_d;
            is_store_q <= is_store_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rd_q       <= rd_d;
            wb_rf_we_q <= wb_rf_we_d;
            wb_data_q  <= wb_data_d;
            wb_exc_q   <= wb_exc_d;
            cause_q    <= cause_d;
            tval_q     <= tval_d;
        end
    end

    assign bus.lsu_ready_o      = (state_q == IDLE);
    assign bus.cpu_req_valid_o  = (state_q == REQ);
    assign bus.cpu_we_o         = is_store_q;
    assign bus.cpu_addr_o       = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign bus.cpu_wdata_o      = wdata_q;
    assign bus.cpu_wstrb_o      = wstrb_q;
    assign bus.cpu_resp_ready_o = (state_q == WAIT_RESP);
    assign bus.wb_valid_o       = (state_q == WB);
    assign bus.wb_rf_we_o       = wb_rf_we_q;
    assign bus.wb_rd_o          = rd_q;
    assign bus.wb_data_o        = wb_data_q;
    assign bus.wb_exc_o         = wb_exc_q;
    assign bus.wb_exc_cause_o   = cause_q;
    assign bus.wb_exc_tval_o    = tval_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_stage
//   Directed bench for lsu_mem_stage. Expected writeback results are pushed
//   to a scoreboard queue when an op is driven and popped when the stage
//   presents wb_valid_o. Request-side expectations are given per step.
//   Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_lsu_mem_stage;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_mem_stage_if bus ();

    lsu_mem_stage dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic        rf_we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exc;
        logic [3:0]  cause;
        logic [31:0] tval;
    } wb_exp_t;

    wb_exp_t sb_q[$];

    int n_checks   = 0;
    int n_fail     = 0;
    int n_req_hs   = 0;
    int n_wb_hs    = 0;
    int exp_req_hs = 0;
    int exp_wb_hs  = 0;

    // Handshake monitor: counts accepted D$ requests and wb completions.
    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.cpu_req_valid_o && bus.dcache_req_ready_i) n_req_hs <= n_req_hs + 1;
            if (bus.wb_valid_o && bus.wb_ready_i)             n_wb_hs  <= n_wb_hs + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic wb_exp_t mk(input logic rf_we, input logic [4:0] rd,
                                   input logic [31:0] data, input logic exc,
                                   input logic [3:0] cause, input logic [31:0] tval);
        wb_exp_t e;
        e.rf_we = rf_we; e.rd = rd; e.data = data;
        e.exc = exc; e.cause = cause; e.tval = tval;
        return e;
    endfunction

    task automatic idle_inputs();
        bus.ex_valid_i          = 1'b0;
        bus.ex_is_store_i       = 1'b0;
        bus.ex_funct3_i         = 3'b000;
        bus.ex_addr_i           = '0;
        bus.ex_wdata_i          = '0;
        bus.ex_rd_i             = '0;
        bus.dcache_req_ready_i  = 1'b0;
        bus.dcache_resp_valid_i = 1'b0;
        bus.dcache_rdata_i      = '0;
        bus.wb_ready_i          = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_lsu_ready"},  bus.lsu_ready_o, 1);
        check({pfx, "_req_valid"},  bus.cpu_req_valid_o, 0);
        check({pfx, "_we"},         bus.cpu_we_o, 0);
        check({pfx, "_addr"},       bus.cpu_addr_o, 0);
        check({pfx, "_wdata"},      bus.cpu_wdata_o, 0);
        check({pfx, "_wstrb"},      bus.cpu_wstrb_o, 0);
        check({pfx, "_resp_ready"}, bus.cpu_resp_ready_o, 0);
        check({pfx, "_wb_valid"},   bus.wb_valid_o, 0);
        check({pfx, "_rf_we"},      bus.wb_rf_we_o, 0);
        check({pfx, "_rd"},         bus.wb_rd_o, 0);
        check({pfx, "_data"},       bus.wb_data_o, 0);
        check({pfx, "_exc"},        bus.wb_exc_o, 0);
        check({pfx, "_cause"},      bus.wb_exc_cause_o, 0);
        check({pfx, "_tval"},       bus.wb_exc_tval_o, 0);
    endtask

    // One complete op. Called and returns on a falling edge with the stage idle.
    task automatic run_op(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rd, input logic [31:0] rdata,
                          input int req_stall, input int wb_stall, input logic fault,
                          input logic [31:0] exp_addr, input logic [3:0] exp_wstrb,
                          input logic [31:0] exp_wdata, input wb_exp_t exp_wb);
        wb_exp_t e;
        check({tag, "_ready_idle"}, bus.lsu_ready_o, 1);
        bus.ex_valid_i    = 1'b1;
        bus.ex_is_store_i = st;
        bus.ex_funct3_i   = f3;
        bus.ex_addr_i     = addr;
        bus.ex_wdata_i    = wdata;
        bus.ex_rd_i       = rd;
        sb_q.push_back(exp_wb);
        exp_wb_hs++;
        if (!fault) exp_req_hs++;
        @(negedge clk);
        // A different op held on ex_* while busy must not be captured.
        bus.ex_valid_i    = (req_stall > 0);
        bus.ex_is_store_i = ~st;
        bus.ex_addr_i     = addr ^ 32'h0000_0104;
        bus.ex_wdata_i    = ~wdata;
        bus.ex_rd_i       = ~rd;
        check({tag, "_ready_busy"}, bus.lsu_ready_o, 0);
        if (fault) begin
            check({tag, "_no_req"}, bus.cpu_req_valid_o, 0);
        end else begin
            for (int i = 0; i <= req_stall; i++) begin
                check({tag, "_req_valid"}, bus.cpu_req_valid_o, 1);
                check({tag, "_we"},        bus.cpu_we_o, st);
                check({tag, "_addr"},      bus.cpu_addr_o, exp_addr);
                check({tag, "_wstrb"},     bus.cpu_wstrb_o, exp_wstrb);
                if (st) check({tag, "_wdata"}, bus.cpu_wdata_o, exp_wdata);
                bus.dcache_req_ready_i  = (i == req_stall);
                // A stray response before the request is accepted is ignored.
                bus.dcache_resp_valid_i = (i < req_stall);
                bus.dcache_rdata_i      = 32'hFFFF_FFFF;
                @(negedge clk);
            end
            bus.ex_valid_i          = 1'b0;
            bus.dcache_req_ready_i  = 1'b0;
            bus.dcache_resp_valid_i = 1'b0;
            check({tag, "_resp_ready"}, bus.cpu_resp_ready_o, 1);
            check({tag, "_req_dropped"}, bus.cpu_req_valid_o, 0);
            bus.dcache_resp_valid_i = 1'b1;
            bus.dcache_rdata_i      = rdata;
            @(negedge clk);
            bus.dcache_resp_valid_i = 1'b0;
            bus.dcache_rdata_i      = 32'h5555_5555;
        end
        bus.ex_valid_i = 1'b0;
        check({tag, "_sb_nonempty"}, (sb_q.size() != 0), 1);
        if (sb_q.size() != 0) e = sb_q.pop_front();
        else e = mk(0, 0, 0, 0, 0, 0);
        for (int i = 0; i <= wb_stall; i++) begin
            check({tag, "_wb_valid"}, bus.wb_valid_o, 1);
            check({tag, "_rf_we"},    bus.wb_rf_we_o, e.rf_we);
            check({tag, "_rd"},       bus.wb_rd_o, e.rd);
            check({tag, "_data"},     bus.wb_data_o, e.data);
            check({tag, "_exc"},      bus.wb_exc_o, e.exc);
            check({tag, "_cause"},    bus.wb_exc_cause_o, e.cause);
            check({tag, "_tval"},     bus.wb_exc_tval_o, e.tval);
            check({tag, "_wb_no_req"}, bus.cpu_req_valid_o, 0);
            bus.wb_ready_i = (i == wb_stall);
            @(negedge clk);
        end
        bus.wb_ready_i = 1'b0;
        check({tag, "_wb_done"},  bus.wb_valid_o, 0);
        check({tag, "_ready_back"}, bus.lsu_ready_o, 1);
    endtask

    initial begin
        idle_inputs();
        #1;
        check_reset_outputs("rst0");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("sw",  1, 3'b010, 32'h1000, 32'hDEAD_BEEF, 0, 0, 0, 0, 0,
               32'h1000, 4'hF, 32'hDEAD_BEEF, mk(0, 0, 32'h0, 0, 0, 0));
        run_op("lb",  0, 3'b000, 32'h2003, 32'h0, 5, 32'h80FF_1234, 0, 0, 0,
               32'h2000, 4'h0, 32'h0, mk(1, 5, 32'hFFFF_FF80, 0, 0, 0));
        run_op("lbu", 0, 3'b100, 32'h2003, 32'h0, 5, 32'h80FF_1234, 0, 0, 0,
               32'h2000, 4'h0, 32'h0, mk(1, 5, 32'h0000_0080, 0, 0, 0));
        run_op("sh",  1, 3'b001, 32'h3002, 32'h0000_ABCD, 0, 0, 0, 0, 0,
               32'h3000, 4'hC, 32'hABCD_ABCD, mk(0, 0, 32'h0, 0, 0, 0));
        run_op("lhu", 0, 3'b101, 32'h3002, 32'h0, 7, 32'hABCD_0000, 0, 0, 0,
               32'h3000, 4'h0, 32'h0, mk(1, 7, 32'h0000_ABCD, 0, 0, 0));
        run_op("lh",  0, 3'b001, 32'h3002, 32'h0, 8, 32'hABCD_0000, 0, 0, 0,
               32'h3000, 4'h0, 32'h0, mk(1, 8, 32'hFFFF_ABCD, 0, 0, 0));
        run_op("sb",  1, 3'b000, 32'h1001, 32'h1234_565A, 0, 0, 0, 0, 0,
               32'h1000, 4'h2, 32'h5A5A_5A5A, mk(0, 0, 32'h0, 0, 0, 0));
        run_op("lw_x0", 0, 3'b010, 32'h4004, 32'h0, 0, 32'h1234_5678, 0, 0, 0,
               32'h4004, 4'h0, 32'h0, mk(0, 0, 32'h1234_5678, 0, 0, 0));

        run_op("lw_mis", 0, 3'b010, 32'h4001, 32'h0, 0, 32'h0, 0, 0, 1,
               32'h0, 4'h0, 32'h0, mk(0, 0, 32'h0, 1, 4'd4, 32'h4001));
        run_op("sh_mis", 1, 3'b001, 32'h4003, 32'h0, 0, 32'h0, 0, 0, 1,
               32'h0, 4'h0, 32'h0, mk(0, 0, 32'h0, 1, 4'd6, 32'h4003));
        run_op("ld_ill", 0, 3'b011, 32'h4003, 32'h0, 0, 32'h0, 0, 0, 1,
               32'h0, 4'h0, 32'h0, mk(0, 0, 32'h0, 1, 4'd2, 32'h0));
        run_op("st_ill", 1, 3'b100, 32'h4000, 32'h0, 0, 32'h0, 0, 0, 1,
               32'h0, 4'h0, 32'h0, mk(0, 0, 32'h0, 1, 4'd2, 32'h0));

        run_op("bp_lw", 0, 3'b010, 32'h5008, 32'h0, 9, 32'hCAFE_F00D, 3, 2, 0,
               32'h5008, 4'h0, 32'h0, mk(1, 9, 32'hCAFE_F00D, 0, 0, 0));

        // Reset while waiting for the D$ response; late response is ignored.
        bus.ex_valid_i    = 1'b1;
        bus.ex_is_store_i = 1'b0;
        bus.ex_funct3_i   = 3'b010;
        bus.ex_addr_i     = 32'h6000;
        bus.ex_rd_i       = 5'd4;
        exp_req_hs++;
        @(negedge clk);
        bus.ex_valid_i         = 1'b0;
        bus.dcache_req_ready_i = 1'b1;
        @(negedge clk);
        bus.dcache_req_ready_i = 1'b0;
        check("rst_fl_resp_ready", bus.cpu_resp_ready_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_fl");
        @(negedge clk);
        rst_n = 1'b1;
        bus.dcache_resp_valid_i = 1'b1;
        bus.dcache_rdata_i      = 32'h7777_7777;
        @(negedge clk);
        bus.dcache_resp_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("rst_late_wb_valid", bus.wb_valid_o, 0);
            check("rst_late_ready",    bus.lsu_ready_o, 1);
            @(negedge clk);
        end

        run_op("post_rst", 0, 3'b010, 32'h6000, 32'h0, 4, 32'h0BAD_F00D, 0, 0, 0,
               32'h6000, 4'h0, 32'h0, mk(1, 4, 32'h0BAD_F00D, 0, 0, 0));

        @(negedge clk);
        check("req_handshakes", n_req_hs, exp_req_hs);
        check("wb_handshakes",  n_wb_hs,  exp_wb_hs);
        check("sb_empty",       sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
